classificador_botao: RTL and testbench
======================================

# classificador_botao

Conditions the raw push-button input and classifies each press as short or long before it reaches the lamp controller's mode logic. The raw pin is synchronised and debounced, and the duration of the stable press is measured. Each press produces exactly one single-cycle event: a long-press event while the button is still held, or a short-press event on release. It sits directly upstream of the controladora mode FSM and shares its DEBOUNCE_P / SWITCH_MODE_MIN_T parameters.

## Interface
- DEBOUNCE_P, default 300: consecutive cycles the synchronised input must disagree with the stable level before the stable level flips. Must be ≥ 1.
- SWITCH_MODE_MIN_T, default 5300: cycles of stable-high press, counted after the FSM registers the press, before a long press is declared. Must be ≥ 2.
- clk, input, 1: single system clock; all flops are rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- push_button, input, 1: raw, asynchronous, bouncing button level (1 = pressed).
- botao_estavel, output, 1: debounced button level.
- pulso_curto, output, 1: one-cycle pulse when a press is released before the long threshold.
- pulso_longo, output, 1: one-cycle pulse when a press reaches the long threshold.

## Operation
- **Synchroniser:** two flops, push_button → s1 → s2. Everything downstream uses s2 only.
- **Debounce counter:**
  - deb_cnt is $clog2(DEBOUNCE_P+1) bits.
  - On each edge where s2 ≠ botao_estavel:
    - if deb_cnt == DEBOUNCE_P-1: botao_estavel ← s2 and deb_cnt ← 0;
    - otherwise deb_cnt increments.
  - On any edge where s2 == botao_estavel: deb_cnt ← 0.
  - A disagreement shorter than DEBOUNCE_P cycles is discarded completely. Rise and fall use the same rule.
- **Hold counter:**
  - hold_cnt is $clog2(SWITCH_MODE_MIN_T+1) bits.
  - It counts only in PRESSIONADO and saturates by construction, because the FSM leaves PRESSIONADO at the threshold.
- **FSM** (registered; it samples the registered botao_estavel):
  - SOLTO:
    - botao_estavel = 1 → PRESSIONADO, hold_cnt ← 0.
    - Otherwise stay.
  - PRESSIONADO, checked in this priority order:
    1. botao_estavel = 0 → SOLTO, assert pulso_curto for one cycle.
    2. hold_cnt == SWITCH_MODE_MIN_T-1 → LONGO, assert pulso_longo for one cycle.
    3. Otherwise hold_cnt increments.
  - LONGO:
    - botao_estavel = 0 → SOLTO, no pulse.
    - Held indefinitely means no further pulses.
- pulso_curto and pulso_longo are registered, mutually exclusive, and never high two consecutive cycles.
- Each accepted press (stable rise) yields exactly one pulse. The only exception is a press interrupted by reset, which yields no pulse.

## Timing
- **Reset values** (asynchronous, immediate on rst=1): s1 = s2 = 0, deb_cnt = 0, hold_cnt = 0, state SOLTO, botao_estavel = 0, pulso_curto = 0, pulso_longo = 0.
- **Edge numbering:** E0 is the first edge at which push_button is sampled high, with the input held clean afterwards.
- **Stable rise:** s2 = 1 after E1; botao_estavel = 1 after E(DEBOUNCE_P+1).
- **FSM entry:** FSM enters PRESSIONADO at E(DEBOUNCE_P+2).
- **Long press:** pulso_longo is high for exactly the cycle after E(DEBOUNCE_P+SWITCH_MODE_MIN_T+2). With defaults this is after E5602, i.e. 5603 sampled-high edges.
- **Release:** with the last high sample at edge R and push_button low from R+1:
  - botao_estavel = 0 after E(R+DEBOUNCE_P+2);
  - pulso_curto (if still in PRESSIONADO) is high after E(R+DEBOUNCE_P+3).
- **Boundary: release versus threshold.** If the release is registered on the same edge where hold_cnt == SWITCH_MODE_MIN_T-1, the release wins: pulso_curto fires and pulso_longo does not.
- **Boundary: glitch length.** A raw glitch of k < DEBOUNCE_P cycles is never visible. A glitch of exactly DEBOUNCE_P cycles flips botao_estavel.
- **Boundary: reset mid-press.** All state clears and no pulse is emitted. If the button is still held when reset is released, botao_estavel rises DEBOUNCE_P+2 edges later and the press is treated as a fresh press.
- **Boundary: bounce during a press.** Bounces shorter than DEBOUNCE_P leave botao_estavel and hold_cnt unaffected.

## Test plan
All scenarios use DEBOUNCE_P=4 and SWITCH_MODE_MIN_T=20.
- **Reset:** assert rst for 3 cycles with push_button=1 → all outputs 0 during reset. After release, botao_estavel = 1 on the 6th edge and no pulse occurs before the press is classified.
- **Glitch rejection:** 3-cycle high pulses separated by 10 low cycles, repeated 10 times → botao_estavel, pulso_curto and pulso_longo stay 0 throughout. A single 4-cycle pulse → botao_estavel goes high.
- **Short press:** hold 10 cycles then release → exactly one pulso_curto, 7 edges after the last high sample. pulso_longo = 0.
- **Long press:** hold 100 cycles → exactly one pulso_longo after edge E26. No pulse on release. botao_estavel returns to 0 after E(R+6).
- **Threshold race:** sweep hold length 20-30 cycles → each press yields exactly one pulse, never both. Longer holds flip from pulso_curto to pulso_longo at a single threshold length.
- **Reset mid-press:** assert rst at E15 of a held press → no pulse. After release of rst with the button still held, pulso_longo fires 26 edges after the first post-reset sampled-high edge.

Source files
------------

// File: rtl/classificador_botao.sv
// Push-button conditioner: two-flop synchroniser, symmetric debounce, and a
// press classifier emitting one registered short- or long-press pulse per press.
module classificador_botao #(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5300
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    output logic botao_estavel,
    output logic pulso_curto,
    output logic pulso_longo
);

    localparam int DEB_W  = $clog2(DEBOUNCE_P + 1);
    localparam int HOLD_W = $clog2(SWITCH_MODE_MIN_T + 1);

    typedef enum logic [1:0] {
        SOLTO,
        PRESSIONADO,
        LONGO
    } estado_t;

    logic              s1;
    logic              s2;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    estado_t           state;
    estado_t           state_next;
    logic              curto_next;
    logic              longo_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= push_button;
            s2 <= s1;
        end
    end

    // Any agreement with the stable level wipes the run, so only an unbroken
    // disagreement of DEBOUNCE_P cycles flips the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt       <= '0;
            botao_estavel <= 1'b0;
        end else if (s2 != botao_estavel) begin
            if (deb_cnt == DEB_W'(DEBOUNCE_P - 1)) begin
                botao_estavel <= s2;
                deb_cnt       <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SOLTO;
            hold_cnt    <= '0;
            pulso_curto <= 1'b0;
            pulso_longo <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            pulso_curto <= curto_next;
            pulso_longo <= longo_next;
        end
    end

    // Release is tested before the threshold so a release landing on the
    // threshold cycle still classifies as short.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        curto_next = 1'b0;
        longo_next = 1'b0;
        case (state)
            SOLTO: begin
                if (botao_estavel) begin
                    state_next = PRESSIONADO;
                    hold_next  = '0;
                end
            end
            PRESSIONADO: begin
                if (!botao_estavel) begin
                    state_next = SOLTO;
                    curto_next = 1'b1;
                end else if (hold_cnt == HOLD_W'(SWITCH_MODE_MIN_T - 1)) begin
                    state_next = LONGO;
                    longo_next = 1'b1;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            LONGO: begin
                if (!botao_estavel) begin
                    state_next = SOLTO;
                end
            end
            default: begin
                state_next = SOLTO;
            end
        endcase
    end

endmodule

// File: tb/tb_classificador_botao.sv
// Self-checking bench for classificador_botao with DEBOUNCE_P=4, SWITCH_MODE_MIN_T=20.
// Edge numbers are relative to the first posedge that samples the press high.
module tb_classificador_botao;

    localparam int DEBOUNCE_P        = 4;
    localparam int SWITCH_MODE_MIN_T = 20;

    typedef struct {
        int len;
        int window;
        int exp_rise;
        int exp_fall;
        int exp_curto;
        int exp_longo;
        int exp_edge;
    } vec_t;

    typedef struct {
        int rise;
        int fall;
        int n_curto;
        int n_longo;
        int curto_edge;
        int longo_edge;
        int bad;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic push_button;
    logic botao_estavel;
    logic pulso_curto;
    logic pulso_longo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    classificador_botao #(
        .DEBOUNCE_P        (DEBOUNCE_P),
        .SWITCH_MODE_MIN_T (SWITCH_MODE_MIN_T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_button   (push_button),
        .botao_estavel (botao_estavel),
        .pulso_curto   (pulso_curto),
        .pulso_longo   (pulso_longo)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_quiet(input string name);
        check_output({name, "_estavel"}, int'(botao_estavel), 0);
        check_output({name, "_curto"}, int'(pulso_curto), 0);
        check_output({name, "_longo"}, int'(pulso_longo), 0);
    endtask

    // Holds the button for len edges (iteration 0 is edge E0), then low, and
    // records when the outputs change over a window of edges.
    task automatic apply_stimulus(input int len, input int window, output obs_t o);
        logic prev;
        o = '{-1, -1, 0, 0, -1, -1, 0};
        prev = 1'b0;
        for (int n = 0; n < window; n++) begin
            @(negedge clk);
            push_button = (n < len);
            @(posedge clk);
            #1;
            if (botao_estavel && o.rise < 0) o.rise = n;
            if (!botao_estavel && o.rise >= 0 && o.fall < 0) o.fall = n;
            if (pulso_curto) begin
                o.n_curto++;
                if (o.curto_edge < 0) o.curto_edge = n;
            end
            if (pulso_longo) begin
                o.n_longo++;
                if (o.longo_edge < 0) o.longo_edge = n;
            end
            if ((pulso_curto && pulso_longo) || ((pulso_curto || pulso_longo) && prev)) o.bad++;
            prev = pulso_curto || pulso_longo;
        end
    endtask

    vec_t vecs[15];
    obs_t o;
    obs_t acc;

    initial begin
        vecs[0]  = '{3,   23,  -1, -1,  0, 0, -1};
        vecs[1]  = '{4,   24,   5,  9,  1, 0, 10};
        vecs[2]  = '{10,  30,   5, 15,  1, 0, 16};
        vecs[3]  = '{20,  40,   5, 25,  1, 0, 26};
        vecs[4]  = '{21,  41,   5, 26,  0, 1, 26};
        vecs[5]  = '{22,  42,   5, 27,  0, 1, 26};
        vecs[6]  = '{23,  43,   5, 28,  0, 1, 26};
        vecs[7]  = '{24,  44,   5, 29,  0, 1, 26};
        vecs[8]  = '{25,  45,   5, 30,  0, 1, 26};
        vecs[9]  = '{26,  46,   5, 31,  0, 1, 26};
        vecs[10] = '{27,  47,   5, 32,  0, 1, 26};
        vecs[11] = '{28,  48,   5, 33,  0, 1, 26};
        vecs[12] = '{29,  49,   5, 34,  0, 1, 26};
        vecs[13] = '{30,  50,   5, 35,  0, 1, 26};
        vecs[14] = '{100, 120,  5, 105, 0, 1, 26};

        rst = 1'b1;
        push_button = 1'b0;
        #1;
        check_quiet("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_held");
        rst = 1'b0;

        // Reset with the button already pressed: the press counts from the
        // first edge after reset release.
        $display("[TB] reset with button held");
        @(negedge clk);
        push_button = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_quiet($sformatf("rst_press_c%0d", c));
        end
        rst = 1'b0;
        apply_stimulus(100, 120, o);
        check_output("rst_press_rise", o.rise, 5);
        check_output("rst_press_ncurto", o.n_curto, 0);
        check_output("rst_press_nlongo", o.n_longo, 1);
        check_output("rst_press_longo_edge", o.longo_edge, 26);
        check_output("rst_press_fall", o.fall, 105);

        $display("[TB] glitch train");
        acc = '{-1, -1, 0, 0, -1, -1, 0};
        for (int g = 0; g < 10; g++) begin
            apply_stimulus(3, 13, o);
            if (o.rise >= 0) acc.rise = o.rise;
            acc.n_curto += o.n_curto;
            acc.n_longo += o.n_longo;
        end
        check_output("glitch_rise", acc.rise, -1);
        check_output("glitch_ncurto", acc.n_curto, 0);
        check_output("glitch_nlongo", acc.n_longo, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].len, vecs[i].window, o);
            check_output($sformatf("v%0d_len%0d_rise", i, vecs[i].len), o.rise, vecs[i].exp_rise);
            check_output($sformatf("v%0d_len%0d_fall", i, vecs[i].len), o.fall, vecs[i].exp_fall);
            check_output($sformatf("v%0d_len%0d_ncurto", i, vecs[i].len), o.n_curto, vecs[i].exp_curto);
            check_output($sformatf("v%0d_len%0d_nlongo", i, vecs[i].len), o.n_longo, vecs[i].exp_longo);
            check_output($sformatf("v%0d_len%0d_curto_edge", i, vecs[i].len), o.curto_edge,
                         (vecs[i].exp_curto != 0) ? vecs[i].exp_edge : -1);
            check_output($sformatf("v%0d_len%0d_longo_edge", i, vecs[i].len), o.longo_edge,
                         (vecs[i].exp_longo != 0) ? vecs[i].exp_edge : -1);
            check_output($sformatf("v%0d_len%0d_pulse_shape", i, vecs[i].len), o.bad, 0);
        end

        // Reset asserted at E15 of a held press, then released with the
        // button still down.
        $display("[TB] reset mid-press");
        apply_stimulus(200, 16, o);
        check_output("mid_pre_rise", o.rise, 5);
        check_output("mid_pre_npulse", o.n_curto + o.n_longo, 0);
        rst = 1'b1;
        #1;
        check_quiet("mid_rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_quiet("mid_rst_held");
        rst = 1'b0;
        apply_stimulus(100, 120, o);
        check_output("mid_post_rise", o.rise, 5);
        check_output("mid_post_ncurto", o.n_curto, 0);
        check_output("mid_post_nlongo", o.n_longo, 1);
        check_output("mid_post_longo_edge", o.longo_edge, 26);
        check_output("mid_post_fall", o.fall, 105);
        check_output("mid_post_pulse_shape", o.bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
